dff_setup_sweep_ctrl: RTL and testbench
=======================================

# dff_setup_sweep_ctrl

Synthesizable sequencer for the DYNDFF setup-time characterization bench. It drives the flip-flop-under-test's data and clock lines, selects the clock and data slew indices, and steps the data-to-clock offset down from a maximum. It digitizes the captured output and reports the smallest passing offset for every (clock slew, data slew) pair over a valid/ready result port. It sits between the bench top level and the analog DFF model, replacing hand-written delay loops with a cycle-exact schedule.

## Interface
- `NB_CK`, 3: number of clock slew points.
- `NB_D`, 3: number of data slew points.
- `OFS_MAX`, 100: first (largest) setup offset, in `clk` cycles.
- `PERIOD`, 200: data-phase length in cycles; must be > `OFS_MAX`.
- `CK_HIGH`, 100: DUT clock high time in cycles.
- `CW`, 16: width of the internal phase counter.

Ports:
- `clk` in 1: sequencer clock; one cycle is one offset step.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: starts a sweep; accepted only in IDLE or DONE.
- `q_in` in 1: digitized DUT output.
- `dut_din` out 1: DUT data.
- `dut_ck` out 1: DUT clock.
- `ck_slew_idx` out $clog2(NB_CK): clock slew selector.
- `d_slew_idx` out $clog2(NB_D): data slew selector.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_ck_idx`, `res_d_idx` out (as above): pair the result belongs to.
- `res_setup` out $clog2(OFS_MAX+1): smallest passing offset.
- `res_found` out 1: at least one offset passed.
- `res_clr_err` out 1: DUT failed to clear during the pair.
- `done` out 1: all pairs reported.

## Operation
- Reset: state IDLE. Every output is 0. Internal indices and offset are 0.
- States:
  - IDLE/DONE: wait for `start`. On `start` go to SLEW with indices 0, ofs=OFS_MAX, found=0, clr_err=0, best=0. `done` clears.
  - SLEW: `PERIOD` cycles. Slew indices change only on entry to SLEW, never during a trial.
  - PRE: `dut_din`=0 for `PERIOD-ofs` cycles. `dut_din` goes to 1 on exit.
  - SETUP: `dut_din`=1, `dut_ck`=0 for `ofs` cycles. Skipped when ofs=0.
  - CKHI: `dut_ck`=1 for `CK_HIGH` cycles. `q_in` is sampled on the last cycle; pass = `q_in`.
  - DLOW: `dut_din`=0, `dut_ck`=0 for `PERIOD` cycles.
  - CLR: `dut_ck`=1 for `CK_HIGH` cycles. `q_in` is sampled on the last cycle; if it is 1, set sticky clr_err.
  - Leaving CLR:
    - If pass: best=ofs, found=1.
    - If ofs==0, or the early-stop condition holds (see Configuration): go to REPORT.
    - Otherwise ofs-=1 and go to PRE.
  - REPORT: `res_valid`=1 with all `res_*` fields stable until `res_valid&&res_ready`. On handshake, `d_slew_idx` increments.
    - Wrap to 0 with `ck_slew_idx`+1.
    - Last pair (NB_CK-1, NB_D-1) goes to DONE. Otherwise go to SLEW with ofs=OFS_MAX and found, best, clr_err cleared.
  - DONE: `done`=1 (level), all DUT drives 0.
- `start` is ignored outside IDLE/DONE.
- Arithmetic: ofs is unsigned, decrements never wrap below 0, counters compare to `param-1`.

## Timing
- Every trial is exactly `2*PERIOD+2*CK_HIGH` cycles (600 at defaults), independent of ofs.
- The rising `dut_din` to rising `dut_ck` distance is exactly `ofs` cycles.
- `res_valid` rises the cycle after the last CLR cycle.
- After the handshake cycle, SLEW (or DONE) is entered on the next cycle.
- `res_ready` may be high before `res_valid`. `res_valid` never drops without a handshake.
- `rst_n` low at any point, including mid-CKHI or mid-REPORT, forces all outputs to 0 asynchronously. The pending result is discarded.

## Configuration
- `SWEEP_EARLY_STOP_EN` defined: leaving CLR with pass=0 and found=1 goes to REPORT immediately. `res_setup` is then the last passing offset.
- Not defined: every pair runs all `OFS_MAX+1` trials. `res_setup` is the smallest passing offset seen; non-monotonic passes are still recorded as minimum.

## Test plan
- DUT model is an ideal DFF that captures iff ofs≥37; `SWEEP_EARLY_STOP_EN` defined. Required response:
  - 9 results, each setup=37, found=1, clr_err=0, pairs in order (0,0),(0,1)..(2,2).
  - 65 trials per pair, then `done`=1.
- Same DUT model, macro undefined:
  - each pair runs 101 trials (60600 cycles);
  - setup=37, found=1.
- DUT threshold 0:
  - setup=0, found=1;
  - SETUP state skipped, so `dut_din` and `dut_ck` rise exactly `PERIOD` cycles after PRE entry.
- DUT threshold 120:
  - found=0, setup=0 for all pairs.
- `res_ready` held low 10 cycles in REPORT, and `q_in` stuck at 1:
  - fields stable and `res_valid` high throughout;
  - indices advance only after the handshake;
  - clr_err=1.
- `rst_n` asserted mid-CKHI of pair (1,2):
  - `dut_ck`=0, `dut_din`=0, `res_valid`=0, `done`=0 immediately;
  - after `start`, the sweep restarts at (0,0) with ofs=100.

Source files
------------

// File: rtl/dff_setup_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dff_setup_sweep_ctrl
// Purpose  : DFF setup-time sweep sequencer: drives DUT data/clock, steps the
//            setup offset down and reports the smallest passing offset per
//            (clock slew, data slew) pair. Optional: SWEEP_EARLY_STOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dff_setup_sweep_ctrl #(
   parameter int NB_CK   = 3,
   parameter int NB_D    = 3,
   parameter int OFS_MAX = 100,
   parameter int PERIOD  = 200,
   parameter int CK_HIGH = 100,
   parameter int CW      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       q_in,
   output logic                       dut_din,
   output logic                       dut_ck,
   output logic [$clog2(NB_CK)-1:0]   ck_slew_idx,
   output logic [$clog2(NB_D)-1:0]    d_slew_idx,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(NB_CK)-1:0]   res_ck_idx,
   output logic [$clog2(NB_D)-1:0]    res_d_idx,
   output logic [$clog2(OFS_MAX+1)-1:0] res_setup,
   output logic                       res_found,
   output logic                       res_clr_err,
   output logic                       done
);

   localparam int CKW = $clog2(NB_CK);
   localparam int DW  = $clog2(NB_D);
   localparam int OW  = $clog2(OFS_MAX+1);

   localparam logic [CW-1:0]  c_period_m1 = CW'(PERIOD - 1);
   localparam logic [CW-1:0]  c_ckhi_m1   = CW'(CK_HIGH - 1);
   localparam logic [CKW-1:0] c_ck_last   = CKW'(NB_CK - 1);
   localparam logic [DW-1:0]  c_d_last    = DW'(NB_D - 1);
   localparam logic [OW-1:0]  c_ofs_max   = OW'(OFS_MAX);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_SLEW   = 4'd1,
      S_PRE    = 4'd2,
      S_SETUP  = 4'd3,
      S_CKHI   = 4'd4,
      S_DLOW   = 4'd5,
      S_CLR    = 4'd6,
      S_REPORT = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OW-1:0]   ofs_q, ofs_d;
   logic [OW-1:0]   best_q, best_d;
   logic            found_q, found_d;
   logic            clr_err_q, clr_err_d;
   logic            pass_q, pass_d;
   logic [CKW-1:0]  ck_idx_q, ck_idx_d;
   logic [DW-1:0]   d_idx_q, d_idx_d;

   logic [CW-1:0]   w_lim;
   logic            w_last;
   logic            w_stop;

`ifdef SWEEP_EARLY_STOP_EN
   assign w_stop = !pass_q && found_q;
`else
   assign w_stop = 1'b0;
`endif

   // PRE shrinks as SETUP grows so every trial has the same length.
   always_comb begin
      w_lim = '0;
      case (state_q)
         S_SLEW, S_DLOW: w_lim = c_period_m1;
         S_PRE:          w_lim = CW'(PERIOD) - CW'(ofs_q) - CW'(1);
         S_SETUP:        w_lim = CW'(ofs_q) - CW'(1);
         S_CKHI, S_CLR:  w_lim = c_ckhi_m1;
         default:        w_lim = '0;
      endcase
   end

   assign w_last = (cnt_q == w_lim);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ofs_q     <= '0;
         best_q    <= '0;
         found_q   <= 1'b0;
         clr_err_q <= 1'b0;
         pass_q    <= 1'b0;
         ck_idx_q  <= '0;
         d_idx_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ofs_q     <= ofs_d;
         best_q    <= best_d;
         found_q   <= found_d;
         clr_err_q <= clr_err_d;
         pass_q    <= pass_d;
         ck_idx_q  <= ck_idx_d;
         d_idx_q   <= d_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      ofs_d     = ofs_q;
      best_d    = best_q;
      found_d   = found_q;
      clr_err_d = clr_err_q;
      pass_d    = pass_q;
      ck_idx_d  = ck_idx_q;
      d_idx_d   = d_idx_q;
      if (w_last) cnt_d = '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            cnt_d = '0;
            if (start) begin
               state_d   = S_SLEW;
               ck_idx_d  = '0;
               d_idx_d   = '0;
               ofs_d     = c_ofs_max;
               best_d    = '0;
               found_d   = 1'b0;
               clr_err_d = 1'b0;
            end
         end
         S_SLEW:  if (w_last) state_d = S_PRE;
         S_PRE:   if (w_last) state_d = (ofs_q == '0) ? S_CKHI : S_SETUP;
         S_SETUP: if (w_last) state_d = S_CKHI;
         S_CKHI: begin
            if (w_last) begin
               pass_d  = q_in;
               state_d = S_DLOW;
            end
         end
         S_DLOW:  if (w_last) state_d = S_CLR;
         S_CLR: begin
            if (w_last) begin
               if (q_in) clr_err_d = 1'b1;
               if (pass_q) begin
                  best_d  = ofs_q;
                  found_d = 1'b1;
               end
               if ((ofs_q == '0) || w_stop) begin
                  state_d = S_REPORT;
               end else begin
                  ofs_d   = ofs_q - OW'(1);
                  state_d = S_PRE;
               end
            end
         end
         S_REPORT: begin
            cnt_d = '0;
            if (res_ready) begin
               if ((ck_idx_q == c_ck_last) && (d_idx_q == c_d_last)) begin
                  state_d  = S_DONE;
                  ck_idx_d = '0;
                  d_idx_d  = '0;
               end else begin
                  state_d   = S_SLEW;
                  ofs_d     = c_ofs_max;
                  best_d    = '0;
                  found_d   = 1'b0;
                  clr_err_d = 1'b0;
                  if (d_idx_q == c_d_last) begin
                     d_idx_d  = '0;
                     ck_idx_d = ck_idx_q + CKW'(1);
                  end else begin
                     d_idx_d  = d_idx_q + DW'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Data stays high through CKHI so the capture edge sees a stable 1.
   assign dut_din     = (state_q == S_SETUP) || (state_q == S_CKHI);
   assign dut_ck      = (state_q == S_CKHI)  || (state_q == S_CLR);
   assign ck_slew_idx = ck_idx_q;
   assign d_slew_idx  = d_idx_q;
   assign res_valid   = (state_q == S_REPORT);
   assign res_ck_idx  = res_valid ? ck_idx_q : '0;
   assign res_d_idx   = res_valid ? d_idx_q  : '0;
   assign res_setup   = res_valid ? best_q   : '0;
   assign res_found   = res_valid && found_q;
   assign res_clr_err = res_valid && clr_err_q;
   assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dff_setup_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_setup_sweep_ctrl
// Purpose  : Self-checking bench with an ideal threshold DFF model and a
//            per-pair reference of expected trials, offsets and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_setup_sweep_ctrl;

   localparam int NB_CK   = 3;
   localparam int NB_D    = 3;
   localparam int OFS_MAX = 10;
   localparam int PERIOD  = 16;
   localparam int CK_HIGH = 4;
   localparam int CW      = 16;
   localparam int TRIAL   = 2*PERIOD + 2*CK_HIGH;
   localparam int LIM     = PERIOD + (OFS_MAX+1)*TRIAL + 20;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, q_in = 1'b0, res_ready = 1'b0;
   logic       dut_din, dut_ck, res_valid, res_found, res_clr_err, done;
   logic [1:0] ck_slew_idx, d_slew_idx, res_ck_idx, res_d_idx;
   logic [3:0] res_setup;

   int  n_cmp = 0, n_err = 0;
   int  thr = 0;
   bit  stuck = 1'b0;
   bit  early;
   int  cyc = 0, t_din = 0;
   logic prev_ck = 1'b0, prev_din = 1'b0, q_model = 1'b0;
   int  dist_q[$];

   dff_setup_sweep_ctrl #(
      .NB_CK(NB_CK), .NB_D(NB_D), .OFS_MAX(OFS_MAX),
      .PERIOD(PERIOD), .CK_HIGH(CK_HIGH), .CW(CW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in),
      .dut_din(dut_din), .dut_ck(dut_ck),
      .ck_slew_idx(ck_slew_idx), .d_slew_idx(d_slew_idx),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_ck_idx(res_ck_idx), .res_d_idx(res_d_idx),
      .res_setup(res_setup), .res_found(res_found),
      .res_clr_err(res_clr_err), .done(done)
   );

   always #5 clk = ~clk;

   // Ideal DFF: captures din at the rising clock iff din led the clock by >= thr cycles.
   always @(negedge clk) begin
      cyc++;
      if (dut_din && !prev_din) t_din = cyc;
      if (dut_ck && !prev_ck) begin
         if (dut_din) begin
            dist_q.push_back(cyc - t_din);
            q_model = ((cyc - t_din) >= thr);
         end else begin
            q_model = 1'b0;
         end
      end
      prev_ck  = dut_ck;
      prev_din = dut_din;
      q_in     = stuck ? 1'b1 : q_model;
   end

   function automatic void model_pair(input int th, input bit stk,
                                      output int n, output int best, output bit found);
      found = 1'b0; best = 0; n = 0;
      for (int o = OFS_MAX; o >= 0; o--) begin
         bit p;
         p = stk || (o >= th);
         n++;
         if (p) begin
            best  = o;
            found = 1'b1;
         end else if (early && found) begin
            break;
         end
      end
   endfunction

   // Entered just after the edge that starts SLEW for pair (ci,di).
   task automatic do_pair(input int ci, input int di, input int stall,
                          input bit rdy_early, input bit poke, output bit ok);
      int  n, best, m;
      bit  found, seq_ok;
      n = 0; best = 0; found = 1'b0;
      model_pair(thr, stuck, n, best, found);
      ok = 1'b1;
      m  = 0;
      dist_q.delete();
      res_ready = rdy_early;
      forever begin
         @(negedge clk);
         start = (poke && m == 3);
         if (m == 0) begin
            n_cmp++;
            if (ck_slew_idx !== ci[1:0] || d_slew_idx !== di[1:0] || done !== 1'b0 || res_valid !== 1'b0)
               $display("FAIL pair_entry(%0d,%0d): idx=(%0d,%0d) done=%b valid=%b, want idx=(%0d,%0d) done=0 valid=0",
                        ci, di, ck_slew_idx, d_slew_idx, done, res_valid, ci, di);
            if (ck_slew_idx !== ci[1:0] || d_slew_idx !== di[1:0] || done !== 1'b0 || res_valid !== 1'b0)
               n_err++;
         end
         if (res_valid) break;
         if (m > LIM) begin
            n_cmp++; n_err++;
            $display("FAIL timeout pair(%0d,%0d): no res_valid after %0d cycles, want %0d", ci, di, m, PERIOD + n*TRIAL);
            ok = 1'b0;
            start = 1'b0;
            return;
         end
         m++;
      end
      start = 1'b0;
      n_cmp++;
      if (m !== PERIOD + n*TRIAL) begin
         n_err++;
         $display("FAIL latency pair(%0d,%0d): got %0d cycles want %0d", ci, di, m, PERIOD + n*TRIAL);
      end
      n_cmp++;
      if (res_ck_idx !== ci[1:0] || res_d_idx !== di[1:0]) begin
         n_err++;
         $display("FAIL res_pair: got (%0d,%0d) want (%0d,%0d)", res_ck_idx, res_d_idx, ci, di);
      end
      n_cmp++;
      if (res_setup !== best[3:0] || res_found !== found || res_clr_err !== stuck) begin
         n_err++;
         $display("FAIL res_fields pair(%0d,%0d): setup=%0d found=%b clr_err=%b want setup=%0d found=%b clr_err=%b",
                  ci, di, res_setup, res_found, res_clr_err, best, found, stuck);
      end
      seq_ok = (dist_q.size() == n);
      for (int i = 0; i < dist_q.size(); i++)
         if (dist_q[i] != OFS_MAX - i) seq_ok = 1'b0;
      n_cmp++;
      if (!seq_ok) begin
         n_err++;
         $display("FAIL offsets pair(%0d,%0d): %0d captures first=%0d, want %0d captures from %0d down by 1",
                  ci, di, dist_q.size(), (dist_q.size() > 0) ? dist_q[0] : -1, n, OFS_MAX);
      end
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         n_cmp++;
         if (res_valid !== 1'b1 || res_setup !== best[3:0] || res_found !== found ||
             res_ck_idx !== ci[1:0] || res_d_idx !== di[1:0] ||
             ck_slew_idx !== ci[1:0] || d_slew_idx !== di[1:0]) begin
            n_err++;
            $display("FAIL stall_hold pair(%0d,%0d) cycle %0d: valid=%b setup=%0d idx=(%0d,%0d) want valid=1 setup=%0d idx=(%0d,%0d)",
                     ci, di, s, res_valid, res_setup, ck_slew_idx, d_slew_idx, best, ci, di);
         end
      end
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic start_sweep();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_sweep(input int th, input bit stk, input int stall_lo, input int stall_hi);
      bit ok;
      int st;
      thr = th; stuck = stk;
      start_sweep();
      for (int ci = 0; ci < NB_CK; ci++) begin
         for (int di = 0; di < NB_D; di++) begin
            st = $urandom_range(stall_hi, stall_lo);
            do_pair(ci, di, st, (st == 0) ? 1'($urandom % 2) : 1'b0, 1'($urandom % 2), ok);
            if (!ok) begin
               @(negedge clk); rst_n = 1'b0;
               @(negedge clk); rst_n = 1'b1;
               return;
            end
         end
      end
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b1 || dut_din !== 1'b0 || dut_ck !== 1'b0 || res_valid !== 1'b0 ||
             ck_slew_idx !== 2'd0 || d_slew_idx !== 2'd0) begin
            n_err++;
            $display("FAIL done_state: done=%b din=%b ck=%b valid=%b idx=(%0d,%0d) want done=1 others 0",
                     done, dut_din, dut_ck, res_valid, ck_slew_idx, d_slew_idx);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({dut_din, dut_ck, ck_slew_idx, d_slew_idx, res_valid, res_ck_idx, res_d_idx,
           res_setup, res_found, res_clr_err, done} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: din=%b ck=%b valid=%b done=%b setup=%0d want all 0",
                  dut_din, dut_ck, res_valid, done, res_setup);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({dut_din, dut_ck, res_valid, done} !== 4'b0) begin
         n_err++;
         $display("FAIL idle_hold: din=%b ck=%b valid=%b done=%b want 0000", dut_din, dut_ck, res_valid, done);
      end
   endtask

   task automatic test_sweep_random();
      run_sweep($urandom_range(OFS_MAX+2, 0), 1'b0, 0, 3);
      run_sweep($urandom_range(OFS_MAX, 1), 1'b0, 0, 2);
   endtask

   task automatic test_threshold_zero();
      run_sweep(0, 1'b0, 0, 1);
   endtask

   task automatic test_never_pass();
      run_sweep(OFS_MAX + 2, 1'b0, 0, 1);
   endtask

   task automatic test_stall_stuck();
      run_sweep($urandom_range(OFS_MAX, 0), 1'b1, 10, 10);
   endtask

   task automatic test_mid_reset();
      bit ok;
      int w;
      thr = $urandom_range(OFS_MAX, 2); stuck = 1'b0;
      start_sweep();
      for (int p = 0; p < 5; p++) begin
         do_pair(p / NB_D, p % NB_D, 0, 1'b1, 1'b0, ok);
         if (!ok) return;
      end
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!(dut_ck === 1'b1 && dut_din === 1'b1) && w < LIM);
      n_cmp++;
      if (w >= LIM || ck_slew_idx !== 2'd1 || d_slew_idx !== 2'd2) begin
         n_err++;
         $display("FAIL mid_reset_reach: waited %0d cycles idx=(%0d,%0d), want CKHI of pair (1,2)", w, ck_slew_idx, d_slew_idx);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_ck !== 1'b0 || dut_din !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 ||
          ck_slew_idx !== 2'd0 || d_slew_idx !== 2'd0) begin
         n_err++;
         $display("FAIL async_reset: ck=%b din=%b valid=%b done=%b idx=(%0d,%0d) want all 0",
                  dut_ck, dut_din, res_valid, done, ck_slew_idx, d_slew_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_sweep($urandom_range(OFS_MAX+2, 0), 1'b0, 0, 2);
   endtask

   initial begin
`ifdef SWEEP_EARLY_STOP_EN
      early = 1'b1;
`else
      early = 1'b0;
`endif
      test_reset();
      test_sweep_random();
      test_threshold_zero();
      test_never_pass();
      test_stall_stuck();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
